// File: rtl/redmule_pkg.sv
// Shared defaults and types for the RedMulE TCDM arbiter slice.
package redmule_pkg;

  localparam int unsigned DATA_W          = 64;
  localparam int unsigned NUM_REQ         = 2;
  localparam int unsigned MAX_OUTSTANDING = 4;
  localparam int unsigned REQ_IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef logic [REQ_IDX_W-1:0] req_idx_t;

endpackage

// File: rtl/redmule_tcdm_rsp_fifo.sv
// In-order FIFO of requester IDs for reads awaiting their TCDM response.
module redmule_tcdm_rsp_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push,
  input  logic                     pop,
  input  logic [Width-1:0]         wdata,
  output logic [Width-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Depth-1:0][Width-1:0] mem;
  logic [PtrW-1:0]             wptr, rptr;
  logic [PtrW:0]               cnt;
  logic                        push_ok, pop_ok;

  assign full    = (cnt == (PtrW+1)'(Depth));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rdata   = mem[rptr];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push_ok) wptr <= wptr + PtrW'(1);
      if (pop_ok)  rptr <= rptr + PtrW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + (PtrW+1)'(1);
        2'b01:   cnt <= cnt - (PtrW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/redmule_tcdm_arbiter.sv
// Round-robin arbiter folding NumReq streamers onto one wide TCDM port,
// with grant locking and in-order routing of read responses.
module redmule_tcdm_arbiter
  import redmule_pkg::*;
#(
  parameter int unsigned NumReq         = NUM_REQ,
  parameter int unsigned DW             = DATA_W,
  parameter int unsigned MaxOutstanding = MAX_OUTSTANDING
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NumReq-1:0]                 req_i,
  output logic [NumReq-1:0]                 gnt_o,
  input  logic [NumReq-1:0][31:0]           add_i,
  input  logic [NumReq-1:0]                 wen_i,
  input  logic [NumReq-1:0][DW/8-1:0]       be_i,
  input  logic [NumReq-1:0][DW-1:0]         data_i,
  output logic [NumReq-1:0]                 r_valid_o,
  output logic [DW-1:0]                     r_data_o,
  output logic                              tcdm_req_o,
  output logic [31:0]                       tcdm_add_o,
  output logic                              tcdm_wen_o,
  output logic [DW/8-1:0]                   tcdm_be_o,
  output logic [DW-1:0]                     tcdm_data_o,
  input  logic                              tcdm_gnt_i,
  input  logic                              tcdm_r_valid_i,
  input  logic [DW-1:0]                     tcdm_r_data_i,
  output logic [$clog2(MaxOutstanding):0]   outstanding_o,
  output logic                              err_o
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  typedef logic [IdxW-1:0] idx_t;

  idx_t ptr_q, lock_idx_q, rr_idx, wr_idx, cand, win, ptr_nxt, head, j;
  logic lock_q, err_q;
  logic rr_vld, wr_vld, lock_hit, cand_vld, cand_blk, blocked, hs;
  logic push, pop, fifo_full, fifo_empty;
  logic [$clog2(MaxOutstanding):0] occ;

  // Walk from the far end back to ptr so the last hit is the first at/after ptr.
  always_comb begin
    rr_vld = 1'b0;
    rr_idx = ptr_q;
    wr_vld = 1'b0;
    wr_idx = ptr_q;
    j      = '0;
    for (int k = int'(NumReq) - 1; k >= 0; k--) begin
      j = idx_t'((int'(ptr_q) + k) % int'(NumReq));
      if (req_i[j]) begin
        rr_vld = 1'b1;
        rr_idx = j;
      end
      if (req_i[j] && !wen_i[j]) begin
        wr_vld = 1'b1;
        wr_idx = j;
      end
    end
  end

  // A lock is honoured only while its owner keeps requesting.
  assign lock_hit = lock_q & req_i[lock_idx_q];
  assign cand     = lock_hit ? lock_idx_q : rr_idx;
  assign cand_vld = lock_hit | rr_vld;
  assign cand_blk = cand_vld & wen_i[cand] & fifo_full;

  always_comb begin
    win     = cand;
    blocked = cand_blk;
    if (cand_blk && wr_vld) begin
      win     = wr_idx;
      blocked = 1'b0;
    end
  end

  assign tcdm_req_o  = cand_vld & ~blocked;
  assign tcdm_add_o  = add_i[win];
  assign tcdm_wen_o  = wen_i[win];
  assign tcdm_be_o   = be_i[win];
  assign tcdm_data_o = data_i[win];
  assign hs          = tcdm_req_o & tcdm_gnt_i;

  always_comb begin
    gnt_o      = '0;
    gnt_o[win] = hs;
  end

  assign push    = hs & wen_i[win];
  assign pop     = tcdm_r_valid_i & ~fifo_empty;
  assign ptr_nxt = (win == idx_t'(NumReq - 1)) ? '0 : win + idx_t'(1);

  always_comb begin
    r_valid_o       = '0;
    r_valid_o[head] = pop;
  end
  assign r_data_o = tcdm_r_data_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (hs) begin
        ptr_q  <= ptr_nxt;
        lock_q <= 1'b0;
      end else begin
        lock_q <= tcdm_req_o;
        if (tcdm_req_o) lock_idx_q <= win;
      end
      if (tcdm_r_valid_i && fifo_empty) err_q <= 1'b1;
    end
  end

  redmule_tcdm_rsp_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdxW)
  ) i_rsp_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (push),
    .pop    (pop),
    .wdata  (win),
    .rdata  (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (occ)
  );

  assign outstanding_o = occ;
  assign err_o         = err_q;

endmodule

// File: tb/tb_redmule_tcdm_arbiter.sv
// Bench for redmule_tcdm_arbiter: directed table, corner sequences, random vs. queue model.
module tb_redmule_tcdm_arbiter;
  import redmule_pkg::*;

  localparam int N  = 2;
  localparam int DW = 64;
  localparam int MO = 4;
  localparam int BW = DW / 8;

  logic                   clk_i = 1'b0;
  logic                   rst_ni = 1'b0;
  logic [N-1:0]           req_i = '0, wen_i = '0;
  logic [N-1:0]           gnt_o, r_valid_o;
  logic [N-1:0][31:0]     add_i;
  logic [N-1:0][BW-1:0]   be_i;
  logic [N-1:0][DW-1:0]   data_i;
  logic [DW-1:0]          r_data_o, tcdm_data_o, tcdm_r_data_i = '0;
  logic                   tcdm_req_o, tcdm_wen_o, err_o;
  logic [31:0]            tcdm_add_o;
  logic [BW-1:0]          tcdm_be_o;
  logic                   tcdm_gnt_i = 1'b0, tcdm_r_valid_i = 1'b0;
  logic [$clog2(MO):0]    outstanding_o;

  redmule_tcdm_arbiter #(.NumReq(N), .DW(DW), .MaxOutstanding(MO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o), .add_i(add_i),
    .wen_i(wen_i), .be_i(be_i), .data_i(data_i), .r_valid_o(r_valid_o), .r_data_o(r_data_o),
    .tcdm_req_o(tcdm_req_o), .tcdm_add_o(tcdm_add_o), .tcdm_wen_o(tcdm_wen_o),
    .tcdm_be_o(tcdm_be_o), .tcdm_data_o(tcdm_data_o), .tcdm_gnt_i(tcdm_gnt_i),
    .tcdm_r_valid_i(tcdm_r_valid_i), .tcdm_r_data_i(tcdm_r_data_i),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: outstanding reads as a queue of requester IDs.
  int  m_ptr, m_lidx, m_q[$];
  bit  m_lock, m_err, m_pend;
  int  e_win;
  bit  e_treq;
  logic [N-1:0] e_gnt, e_rv;

  function automatic void model_eval();
    int cand, alt;
    bit blk;
    cand = -1;
    alt  = -1;
    if (m_lock && req_i[m_lidx]) cand = m_lidx;
    else
      for (int k = 0; k < N; k++) begin
        int i = (m_ptr + k) % N;
        if (req_i[i] && cand < 0) cand = i;
      end
    for (int k = 0; k < N; k++) begin
      int i = (m_ptr + k) % N;
      if (req_i[i] && !wen_i[i] && alt < 0) alt = i;
    end
    blk   = (cand >= 0) && wen_i[cand] && (m_q.size() == MO);
    e_win = cand;
    if (blk && alt >= 0) begin
      e_win = alt;
      blk   = 1'b0;
    end
    e_treq = (cand >= 0) && !blk;
    e_gnt  = (e_treq && tcdm_gnt_i) ? N'(1 << e_win) : '0;
    e_rv   = (tcdm_r_valid_i && m_q.size() > 0) ? N'(1 << m_q[0]) : '0;
  endfunction

  function automatic void model_step();
    if (tcdm_r_valid_i) begin
      if (m_q.size() > 0) void'(m_q.pop_front());
      else m_err = 1'b1;
    end
    if (e_treq && tcdm_gnt_i) begin
      if (wen_i[e_win]) m_q.push_back(e_win);
      m_ptr  = (e_win + 1) % N;
      m_lock = 1'b0;
    end else if (e_treq) begin
      m_lock = 1'b1;
      m_lidx = e_win;
    end else begin
      m_lock = 1'b0;
    end
  endfunction

  task automatic drive(input logic [N-1:0] r, input logic [N-1:0] w, input logic g,
                       input logic rv, input bit rnd);
    if (m_pend) model_step();
    @(negedge clk_i);
    req_i          = r;
    wen_i          = w;
    tcdm_gnt_i     = g;
    tcdm_r_valid_i = rv;
    tcdm_r_data_i  = {$urandom, $urandom};
    if (rnd)
      for (int i = 0; i < N; i++) begin
        add_i[i]  = $urandom;
        be_i[i]   = BW'($urandom);
        data_i[i] = {$urandom, $urandom};
      end
    #1;
    model_eval();
    m_pend = 1'b1;
  endtask

  task automatic set_payload();
    add_i[0] = 32'h100; add_i[1] = 32'h200;
    be_i[0] = 8'h0F; be_i[1] = 8'hF0;
    data_i[0] = 64'hAAAA_0000_0000_0001; data_i[1] = 64'hBBBB_0000_0000_0002;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    req_i = '0; wen_i = '0; tcdm_gnt_i = 1'b0; tcdm_r_valid_i = 1'b0;
    #1;
    chk("rst_outstanding", outstanding_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_gnt_rvalid_req", {gnt_o, r_valid_o, tcdm_req_o}, 0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    m_ptr = 0; m_lock = 1'b0; m_lidx = 0; m_err = 1'b0; m_pend = 1'b0;
    m_q.delete();
  endtask

  typedef struct {
    logic [N-1:0] req, wen;
    logic         g, rv;
    logic [N-1:0] e_gnt, e_rv;
    logic         e_treq;
    logic [31:0]  e_add;
    logic [2:0]   e_out;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Both streamers reading back-to-back with 1-cycle responses, then a held write.
    tbl[0] = '{2'b11, 2'b11, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 32'h100, 3'd0};
    tbl[1] = '{2'b11, 2'b11, 1'b1, 1'b1, 2'b10, 2'b01, 1'b1, 32'h200, 3'd1};
    tbl[2] = '{2'b11, 2'b11, 1'b1, 1'b1, 2'b01, 2'b10, 1'b1, 32'h100, 3'd1};
    tbl[3] = '{2'b11, 2'b11, 1'b1, 1'b1, 2'b10, 2'b01, 1'b1, 32'h200, 3'd1};
    tbl[4] = '{2'b01, 2'b00, 1'b1, 1'b1, 2'b01, 2'b10, 1'b1, 32'h100, 3'd1};
    tbl[5] = '{2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 32'h200, 3'd0};
    tbl[6] = '{2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 32'h200, 3'd0};
    tbl[7] = '{2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 32'h200, 3'd0};
    tbl[8] = '{2'b11, 2'b00, 1'b1, 1'b0, 2'b10, 2'b00, 1'b1, 32'h200, 3'd0};

    set_payload();
    m_pend = 1'b0;
    do_reset();

    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].req, tbl[i].wen, tbl[i].g, tbl[i].rv, 1'b0);
      chk($sformatf("tbl%0d_gnt", i), gnt_o, tbl[i].e_gnt);
      chk($sformatf("tbl%0d_rvalid", i), r_valid_o, tbl[i].e_rv);
      chk($sformatf("tbl%0d_treq", i), tcdm_req_o, tbl[i].e_treq);
      chk($sformatf("tbl%0d_add", i), tcdm_add_o, tbl[i].e_add);
      chk($sformatf("tbl%0d_out", i), outstanding_o, tbl[i].e_out);
      if (tbl[i].e_rv != '0) chk($sformatf("tbl%0d_rdata", i), r_data_o, tcdm_r_data_i);
    end

    // Full response FIFO: writes bypass a blocked read; a pop does not unblock same cycle.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(2'b01, 2'b01, 1'b1, 1'b0, 1'b0);
      chk("full_fill_gnt", gnt_o, 2'b01);
      chk("full_fill_out", outstanding_o, i);
    end
    drive(2'b11, 2'b01, 1'b1, 1'b0, 1'b0);
    chk("full_wr_gnt", gnt_o, 2'b10);
    chk("full_out4", outstanding_o, 4);
    drive(2'b11, 2'b01, 1'b1, 1'b0, 1'b0);
    chk("full_wr_bypass_gnt", gnt_o, 2'b10);
    drive(2'b01, 2'b01, 1'b1, 1'b0, 1'b0);
    chk("full_blocked_gnt", {tcdm_req_o, gnt_o}, 3'b000);
    drive(2'b01, 2'b01, 1'b1, 1'b1, 1'b0);
    chk("full_pop_gnt", gnt_o, 2'b00);
    chk("full_pop_rvalid", r_valid_o, 2'b01);
    drive(2'b01, 2'b01, 1'b1, 1'b0, 1'b0);
    chk("full_after_pop_gnt", gnt_o, 2'b01);
    chk("full_after_pop_out", outstanding_o, 3);
    drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("full_refill_out", outstanding_o, 4);

    // Orphan response sets sticky error until reset.
    do_reset();
    drive(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("orphan_rvalid", r_valid_o, 2'b00);
    chk("orphan_err_pre", err_o, 0);
    for (int i = 0; i < 3; i++) begin
      drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
      chk("orphan_err_sticky", err_o, 1);
    end

    // Reset with reads in flight discards their IDs.
    do_reset();
    for (int i = 0; i < 3; i++) drive(2'b01, 2'b01, 1'b1, 1'b0, 1'b0);
    drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("midrst_out3", outstanding_o, 3);
    do_reset();
    drive(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("midrst_late_rvalid", r_valid_o, 2'b00);
    drive(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("midrst_late_err", err_o, 1);
    chk("midrst_late_out", outstanding_o, 0);

    // Random traffic against the queue model.
    for (int blk = 0; blk < 4; blk++) begin
      do_reset();
      for (int c = 0; c < 500; c++) begin
        drive(N'($urandom), N'($urandom), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 99) < 35), 1'b1);
        chk("rnd_gnt", gnt_o, e_gnt);
        chk("rnd_treq", tcdm_req_o, e_treq);
        if (e_treq) begin
          chk("rnd_add", tcdm_add_o, add_i[e_win]);
          chk("rnd_wen_be", {tcdm_wen_o, tcdm_be_o}, {wen_i[e_win], be_i[e_win]});
          chk("rnd_data", tcdm_data_o, data_i[e_win]);
        end
        chk("rnd_rvalid", r_valid_o, e_rv);
        if (e_rv != '0) chk("rnd_rdata", r_data_o, tcdm_r_data_i);
        chk("rnd_out", outstanding_o, m_q.size());
        chk("rnd_err", err_o, m_err);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/redmule_tcdm_arbiter.md
REDMULE_TCDM_ARBITER -- requirements
Module: redmule_tcdm_arbiter

Interface
REQ-001 Parameter NumReq, default 2: number of requesters (streamers) sharing the one wide TCDM master port.
REQ-002 Parameter DW, default DATA_W: port data width in bits; a multiple of 32.
REQ-003 Parameter MaxOutstanding, default 4: read responses that may be in flight; a power of two, at least 2.
REQ-004 Clock and reset: one clock, clk_i; reset rst_ni is asynchronous and active-low.
REQ-005 clk_i  in  1  clock.
REQ-006 rst_ni  in  1  async active-low reset.
REQ-007 req_i  in  NumReq  per-requester request.
REQ-008 gnt_o  out  NumReq  per-requester grant, one-hot or zero.
REQ-009 add_i  in  NumReq x 32  byte address.
REQ-010 wen_i  in  NumReq  1 = read, 0 = write.
REQ-011 be_i  in  NumReq x DW/8  byte enables.
REQ-012 data_i  in  NumReq x DW  write data.
REQ-013 r_valid_o  out  NumReq  response valid routed to the originating requester, one-hot or zero.
REQ-014 r_data_o  out  DW  response data, shared by all requesters.
REQ-015 tcdm_req_o, tcdm_add_o[32], tcdm_wen_o, tcdm_be_o[DW/8], tcdm_data_o[DW]  out  master request channel.
REQ-016 tcdm_gnt_i, tcdm_r_valid_i  in  1  master grant and response valid.
REQ-017 tcdm_r_data_i  in  DW  master response data.
REQ-018 outstanding_o  out  clog2(MaxOutstanding)+1  number of reads in flight.
REQ-019 err_o  out  1  sticky: a response arrived with no read in flight.

Function
REQ-020 The block SHALL select one winner per cycle by round-robin, starting the search at priority pointer ptr.
REQ-021 The winner's address, wen, be and data SHALL drive tcdm_*_o combinationally; tcdm_req_o = req_i[winner] AND NOT blocked.
REQ-022 blocked SHALL be 1 when the winner is a read and the response FIFO is full; writes are never blocked.
REQ-023 When the winner is blocked, the arbiter SHALL pick the lowest index at or after ptr that is an unblocked write, if one exists.
REQ-024 gnt_o[winner] = tcdm_gnt_i AND tcdm_req_o; every other gnt_o bit SHALL be 0.
REQ-025 Lock: if tcdm_req_o=1 and tcdm_gnt_i=0, the winner SHALL be held in a lock register and re-selected every cycle until granted, with no switching.
REQ-026 On each handshake, ptr SHALL become (winner+1) mod NumReq and the lock SHALL clear.
REQ-027 A granted read SHALL push the winner index into an in-order FIFO of depth MaxOutstanding.
REQ-028 On tcdm_r_valid_i with the FIFO non-empty, r_valid_o[head]=1 and r_data_o=tcdm_r_data_i in the same cycle; the FIFO then pops.
REQ-029 Simultaneous push and pop SHALL keep occupancy unchanged; ordering SHALL be preserved.
REQ-030 On tcdm_r_valid_i with the FIFO empty, r_valid_o SHALL stay 0, the response SHALL be dropped, and err_o SHALL be set until reset.
REQ-031 Full FIFO: a pop in the same cycle SHALL NOT unblock a read; blocked is computed from registered occupancy.
REQ-032 A requester that drops req_i while locked SHALL release the lock; ptr SHALL be unchanged.
REQ-033 outstanding_o SHALL equal the registered FIFO occupancy.

Reset
REQ-034 On reset: ptr=0, lock clear, FIFO empty, outstanding_o=0, err_o=0, gnt_o=0, r_valid_o=0, tcdm_req_o=0.
REQ-035 A reset mid-transaction SHALL discard all in-flight read IDs; no r_valid_o is issued for them afterwards.

Structure
REQ-036 Default NumReq and MaxOutstanding SHALL be localparams in redmule_pkg; the requester-index type SHALL be typedef'd there.
REQ-037 The response-ID FIFO SHALL be a sub-module named redmule_tcdm_rsp_fifo, with push, pop, data, full, empty and count.

Verification
REQ-038 Requesters 0 and 1 both issue reads continuously, tcdm_gnt_i=1, response latency 1 -> grants alternate 0,1,0,1; each r_valid_o reaches its own requester in order.
REQ-039 Requester 1 writes with tcdm_gnt_i=0 for 3 cycles while requester 0 also requests -> tcdm_add_o stays at requester 1's address for 4 cycles, then gnt_o=2'b10.
REQ-040 MaxOutstanding=4, responses withheld, requester 0 issues 5 reads -> 4 grants, outstanding_o=4; a pending write from requester 1 is granted; the 5th read is granted only the cycle after the first response.
REQ-041 tcdm_r_valid_i pulsed after reset with no requests -> r_valid_o=0 and err_o=1 held until rst_ni=0.
REQ-042 rst_ni asserted with 3 reads outstanding, then late responses -> outstanding_o=0, no r_valid_o, and err_o=1 on the first late response.
